// File: rtl/store_sequencer.sv
// store_sequencer
//   Store path from the register file to word-wide memory. Word stores write
//   directly. Half-word and byte stores do a read-modify-write: read the
//   containing word, replace the selected lane, then write the word back.
//   The control unit pulses start and stalls until done.
//
// Parameters
//   MEM_LAT    read latency, in cycles, from mem_addr to valid mem_rdata (1..3)
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      begin a store; a rising edge is accepted only in IDLE
//   store_size 00 word, 01 half, 10 byte, 11 reserved (treated as word)
//   addr       byte address
//   wdata      store data; the low byte or half is used for sb/sh
//   mem_rdata  memory read data
//   mem_addr   word-aligned memory address; holds its last value in IDLE
//   mem_wdata  word to write (merged word for sub-word stores)
//   mem_wr     one-cycle memory write strobe
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   align_err  misaligned-access flag, pulses together with done
//
// Build option
//   STORE_ALIGN_CHECK_EN  When defined, a half store with addr[0]=1 or a word
//                         store with addr[1:0]!=0 is rejected without any
//                         memory access. When undefined, the low address bits
//                         are ignored and align_err is tied low.
module store_sequencer #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  store_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        align_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
`ifdef STORE_ALIGN_CHECK_EN
    , S_ERR
`endif
  } state_t;

  state_t      state;
  logic        start_q;
  logic [1:0]  off_l;
  logic [1:0]  size_l;
  logic [31:0] wdata_l;
  logic [1:0]  cnt;
  logic [31:0] merged;
  logic        start_rise;
  logic        is_word;

  assign start_rise = start && !start_q;
  assign is_word    = (store_size == 2'b00) || (store_size == 2'b11);

`ifdef STORE_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = ((store_size == 2'b01) && addr[0]) ||
                      (is_word && (addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif

  // Replace one lane of the word read back; the other lanes are kept.
  always_comb begin
    merged = mem_rdata;
    if (size_l == 2'b01) begin
      if (off_l[1]) merged[31:16] = wdata_l[15:0];
      else          merged[15:0]  = wdata_l[15:0];
    end else begin
      case (off_l)
        2'd0: merged[7:0]   = wdata_l[7:0];
        2'd1: merged[15:8]  = wdata_l[7:0];
        2'd2: merged[23:16] = wdata_l[7:0];
        2'd3: merged[31:24] = wdata_l[7:0];
      endcase
    end
  end

  // Outputs are registered: each one is set on the edge that enters the
  // state in which it must be visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      off_l     <= '0;
      size_l    <= '0;
      wdata_l   <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
      align_err <= 1'b0;
`endif
    end else begin
      start_q <= start;
      mem_wr  <= 1'b0;
      done    <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
      align_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start_rise) begin
            off_l    <= addr[1:0];
            size_l   <= store_size;
            wdata_l  <= wdata;
            mem_addr <= {addr[31:2], 2'b00};
            busy     <= 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
            if (misaligned) begin
              done      <= 1'b1;
              align_err <= 1'b1;
              state     <= S_ERR;
            end else
`endif
            if (is_word) begin
              mem_wdata <= wdata;
              mem_wr    <= 1'b1;
              state     <= S_WRITE;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          cnt   <= 2'(MEM_LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 2'd0) begin
            mem_wdata <= merged;
            mem_wr    <= 1'b1;
            state     <= S_WRITE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        S_WRITE: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`ifdef STORE_ALIGN_CHECK_EN
        S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Bench for store_sequencer: two instances (MEM_LAT=1 and MEM_LAT=3) share the
// stimulus, each with its own word memory. A transaction-level model predicts
// the cycle of the write and of done, the address and the merged word; a
// compare process checks every cycle. Directed runs also carry literal
// latency/data expectations.
module tb_store_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start = 1'b0;
  logic [1:0]  store_size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] ma [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic        wr [2];
  logic        dn [2];
  logic        bz [2];
  logic        ae [2];

  always #5 clk = ~clk;

  store_sequencer #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .start(start), .store_size(store_size),
    .addr(addr), .wdata(wdata), .mem_rdata(rd[0]), .mem_addr(ma[0]),
    .mem_wdata(wd[0]), .mem_wr(wr[0]), .busy(bz[0]), .done(dn[0]),
    .align_err(ae[0]));

  store_sequencer #(.MEM_LAT(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .start(start), .store_size(store_size),
    .addr(addr), .wdata(wdata), .mem_rdata(rd[1]), .mem_addr(ma[1]),
    .mem_wdata(wd[1]), .mem_wr(wr[1]), .busy(bz[1]), .done(dn[1]),
    .align_err(ae[1]));

  // Memories: registered read pipelines of depth 1 and 3, plus a preload port.
  logic [31:0] mem [2][256];
  logic [31:0] rp  [2][3];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pl_en) mem[d][pl_idx] <= pl_val;
      else if (wr[d]) mem[d][ma[d][9:2]] <= wd[d];
      rp[d][0] <= mem[d][ma[d][9:2]];
      rp[d][1] <= rp[d][0];
      rp[d][2] <= rp[d][1];
    end
  end
  assign rd[0] = rp[0][0];
  assign rd[1] = rp[1][2];

  // Transaction model. t counts cycles from the accepting edge: t=1 is the
  // first cycle after it, matching "cycle k+1" in the latency rules.
  bit          act [2];
  bit          er [2];
  int          t [2];
  int          wr_t [2];
  int          dn_t [2];
  logic [31:0] e_addr [2];
  logic [31:0] e_wd [2];
  logic        sprev;
  int          lat_m;
  int          sh_m;
  logic [31:0] old_m;
  logic [31:0] msk_m;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      sprev = 1'b0;
      for (int d = 0; d < 2; d++) begin
        act[d] = 0; er[d] = 0; t[d] = 0; wr_t[d] = 0; dn_t[d] = 0;
        e_addr[d] = '0; e_wd[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (act[d]) begin
          if (t[d] == dn_t[d]) act[d] = 0;
          else t[d] = t[d] + 1;
        end else if (start && !sprev) begin
          lat_m = (d == 0) ? 1 : 3;
          old_m = mem[d][addr[9:2]];
          e_addr[d] = addr & 32'hFFFF_FFFC;
          act[d] = 1; t[d] = 1; er[d] = 0;
          if (store_size == 2'b01 || store_size == 2'b10) begin
            if (store_size == 2'b10) begin
              sh_m = addr[1:0] * 8;  msk_m = 32'h0000_00FF << sh_m;
            end else begin
              sh_m = addr[1] * 16;   msk_m = 32'h0000_FFFF << sh_m;
            end
            e_wd[d] = (old_m & ~msk_m) | ((wdata << sh_m) & msk_m);
            wr_t[d] = 2 + lat_m;
            dn_t[d] = 3 + lat_m;
`ifdef STORE_ALIGN_CHECK_EN
            if (store_size == 2'b01 && addr[0]) er[d] = 1;
`endif
          end else begin
            e_wd[d] = wdata;
            wr_t[d] = 1;
            dn_t[d] = 2;
`ifdef STORE_ALIGN_CHECK_EN
            if (addr[1:0] != 2'b00) er[d] = 1;
`endif
          end
          if (er[d]) begin wr_t[d] = 0; dn_t[d] = 1; end
        end
      end
      sprev = start;
    end
  end

  // Literal expectations supplied by the directed runs.
  bit          lit_en = 0;
  logic [31:0] lit_wd = '0;
  int          lit_wr [2];
  int          lit_dn [2];

  int total = 0;
  int bad = 0;
  int tmo_req = 0;
  int tmo_seen = 0;

  task automatic chk(input string n, input int d, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s lat%0d: got %h want %h at %0t", n, (d == 0) ? 1 : 3, a, e, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (tmo_req != tmo_seen) begin
      tmo_seen++; total++; bad++;
      $display("FAIL timeout: got busy want idle at %0t", $time);
    end
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        chk("rst_mem_wr", d, 32'(wr[d]), 32'd0);
        chk("rst_done",   d, 32'(dn[d]), 32'd0);
        chk("rst_busy",   d, 32'(bz[d]), 32'd0);
        chk("rst_aerr",   d, 32'(ae[d]), 32'd0);
        chk("rst_addr",   d, ma[d], 32'd0);
        chk("rst_wdata",  d, wd[d], 32'd0);
      end else begin
        chk("mem_wr",    d, 32'(wr[d]), 32'(act[d] && t[d] == wr_t[d]));
        chk("done",      d, 32'(dn[d]), 32'(act[d] && t[d] == dn_t[d]));
        chk("busy",      d, 32'(bz[d]), 32'(act[d]));
        chk("align_err", d, 32'(ae[d]), 32'(act[d] && er[d] && t[d] == dn_t[d]));
        chk("mem_addr",  d, ma[d], e_addr[d]);
        if (act[d] && t[d] == wr_t[d]) chk("mem_wdata", d, wd[d], e_wd[d]);
        if (lit_en && wr[d]) begin
          chk("lit_wr_cycle", d, 32'(t[d]), 32'(lit_wr[d]));
          chk("lit_wdata",    d, wd[d], lit_wd);
        end
        if (lit_en && dn[d]) chk("lit_done_cycle", d, 32'(t[d]), 32'(lit_dn[d]));
      end
    end
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((act[0] || act[1] || bz[0] || bz[1]) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (act[0] || act[1] || bz[0] || bz[1]) tmo_req++;
    @(negedge clk);
  endtask

  // lw*/ld*: expected write/done cycle for lat1 and lat3 (write 0 = no write).
  task automatic run(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w,
                     input logic [31:0] lwd, input int lw0, input int lw1,
                     input int ld0, input int ld1, input int hold);
    lit_wd = lwd; lit_wr[0] = lw0; lit_wr[1] = lw1; lit_dn[0] = ld0; lit_dn[1] = ld1;
    lit_en = 1;
    @(negedge clk);
    store_size = sz; addr = a; wdata = w; start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    wait_idle();
    lit_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

  initial begin
    lit_wr[0] = 0; lit_wr[1] = 0; lit_dn[0] = 0; lit_dn[1] = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // sw: direct write, no read cycle
    run(2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1, 2, 2, 1);

    // sb to offset 3, then offsets 1
    preload(8'h80, 32'h1122_3344);
    run(2'b10, 32'h0000_0203, 32'h0000_00AA, 32'hAA22_3344, 3, 5, 4, 6, 1);
    preload(8'h80, 32'h1122_3344);
    run(2'b10, 32'h0000_0201, 32'hFFFF_FF55, 32'h1122_5544, 3, 5, 4, 6, 1);

    // sh upper and lower lanes
    preload(8'h80, 32'h1122_3344);
    run(2'b01, 32'h0000_0202, 32'h0000_CAFE, 32'hCAFE_3344, 3, 5, 4, 6, 1);
    preload(8'h80, 32'h1122_3344);
    run(2'b01, 32'h0000_0200, 32'h0000_CAFE, 32'h1122_CAFE, 3, 5, 4, 6, 1);

    // reserved size behaves as word
    run(2'b11, 32'h0000_0300, 32'h1234_5678, 32'h1234_5678, 1, 1, 2, 2, 1);

    // misaligned half and word (address wrap)
    preload(8'h80, 32'h1122_3344);
`ifdef STORE_ALIGN_CHECK_EN
    run(2'b01, 32'h0000_0201, 32'h0000_CAFE, 32'h0000_0000, 0, 0, 1, 1, 1);
    run(2'b00, 32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h0000_0000, 0, 0, 1, 1, 1);
`else
    run(2'b01, 32'h0000_0201, 32'h0000_CAFE, 32'h1122_CAFE, 3, 5, 4, 6, 1);
    run(2'b00, 32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 1, 2, 2, 1);
`endif

    // reset during WAIT of an sb: no write, outputs cleared before next edge
    preload(8'h80, 32'h1122_3344);
    @(negedge clk);
    store_size = 2'b10; addr = 32'h0000_0203; wdata = 32'h0000_00AA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run(2'b10, 32'h0000_0203, 32'h0000_00AA, 32'hAA22_3344, 3, 5, 4, 6, 1);

    // start held high for 6 cycles: one store only
    preload(8'h80, 32'h1122_3344);
    run(2'b01, 32'h0000_0202, 32'h0000_BEEF, 32'hBEEF_3344, 3, 5, 4, 6, 6);

    // normal word store after everything
    run(2'b00, 32'h0000_0104, 32'hCAFE_BABE, 32'hCAFE_BABE, 1, 1, 2, 2, 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_sequencer.md
Name: store_sequencer

Overview:
- Drives the register-to-memory store path; it is the write-to-memory counterpart of the register write-data selection path.
- Executes sw/sh/sb against word-wide memory with one-cycle-registered synchronous reads.
- Sub-word stores use read-modify-write; word stores write directly.
- The control unit pulses start and stalls until done.

Parameters:
MEM_LAT, 1, read latency in cycles from address presented to mem_rdata valid (1..3)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin store; sampled only in IDLE
store_size  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
addr  input  32  byte address (ALU result)
wdata  input  32  register B value; low byte/half used for sb/sh
mem_rdata  input  32  memory read data
mem_addr  output  32  word-aligned memory address
mem_wdata  output  32  merged write word
mem_wr  output  1  memory write strobe, one cycle
busy  output  1  high in any state except IDLE
done  output  1  one-cycle completion pulse
align_err  output  1  misaligned access flag (feature-dependent)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, align_err=0; latched operands=0. Asserting reset mid-operation aborts immediately. mem_wr drops asynchronously and no partial write completes.
- On a start edge in IDLE, latch addr, wdata and store_size. start outside IDLE is ignored; it is not queued.
- mem_addr = {addr_l[31:2],2'b00} from the cycle after start until return to IDLE; it holds its last value in IDLE.
- Byte lanes are little-endian: offset 0 is bits 7:0 and offset 3 is bits 31:24. Half lane: addr[1]=0 is bits 15:0, =1 is bits 31:16.
- FSM states: IDLE, READ, WAIT, WRITE, DONE, ERR.
  - IDLE: start and word -> WRITE; start and half/byte -> READ.
  - READ: one cycle; mem_wr=0; wait counter loaded with MEM_LAT-1 -> WAIT.
  - WAIT: hold until counter=0. At that edge, capture mem_rdata, replace the selected lane with wdata_l[7:0] or [15:0], keep other lanes, and place the result in mem_wdata -> WRITE.
  - WRITE: mem_wr=1 for exactly one cycle. mem_wdata = merged word, or wdata_l for word stores -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: done=1 and align_err=1 for one cycle, no write -> IDLE.
- Latency (start high at edge k):
  - Word: mem_wr high in cycle k+1, done in k+2.
  - Sub-word: mem_wr high in cycle k+2+MEM_LAT, done in k+3+MEM_LAT.
- busy rises the cycle after the start edge and falls in the cycle after DONE/ERR.
- mem_wr is never high outside WRITE. mem_wr and done are never high together.
- Address wrap: addr=0xFFFFFFFF yields mem_addr=0xFFFFFFFC. No carry, no special handling.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, goes IDLE -> ERR. No memory access occurs and align_err pulses with done.
- Undefined: no check. Low address bits are ignored for word stores, and addr[0] is ignored for half stores (lane chosen by addr[1]). align_err is tied to 0 and the ERR state is not built.

Test Plan:
1. sw, addr=0x100, wdata=0xDEADBEEF -> mem_wr at k+1 with mem_addr=0x100 and mem_wdata=0xDEADBEEF; done at k+2; no read cycle.
2. sb, addr=0x203, wdata=0x000000AA, memory word 0x11223344, MEM_LAT=1 -> mem_wr at k+3 with mem_wdata=0xAA223344; done at k+4.
3. sh, addr=0x202, wdata=0x0000CAFE, memory 0x11223344 -> mem_wdata=0xCAFE3344. Repeat with addr=0x200 -> 0x1122CAFE.
4. reset_n low while in WAIT of an sb -> mem_wr never asserts; outputs go to 0 immediately; a next start after release runs normally.
5. start held high for 6 cycles during an sh -> exactly one mem_wr and one done. A second store begins only on a start edge sampled in IDLE.
6. sh with addr=0x201:
   - STORE_ALIGN_CHECK_EN defined -> done and align_err at k+1, no mem_wr.
   - Undefined -> write to lane 15:0 at 0x200.
   - Also rerun test 2 with MEM_LAT=3 -> mem_wr at k+5.
